mem_io_sequencer: RTL

//  Multi-cycle load/store sequencer between the EX/MEM stage and the data memory / MMIO bus.

---
 rtl/mem_io_sequencer.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_io_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mem_io_sequencer
//  Description : Multi-cycle load/store sequencer sitting between the EX/MEM
//                stage and the data memory / MMIO bus. Decodes the target
//                region, runs fixed-latency memory accesses or req/ack I/O
//                accesses with a timeout, stalls the pipeline meanwhile and
//                returns formatted lb/lbu/lw data with an error flag.
//  Ports       : clk_i/rst_i          clock, async active-high reset
//                req_valid_i, opcode_i, funct3_i, addr_i, wdata_i
//                                     access request from EX/MEM
//                stall_o, done_o, rdata_o, err_o
//                                     pipeline control and write-back data
//                bus_addr_o, bus_wdata_o
//                                     shared bus address / store data
//                mem_re_o, mem_we_o, mem_be_o, mem_rdata_i
//                                     data memory port
//                io_re_o, io_we_o, io_ack_i, io_rdata_i
//                                     MMIO handshake port
//  Revision    : 1.0  initial release
// ============================================================================
module mem_io_sequencer #(
    parameter int          MEM_RD_LAT = 2,
    parameter int          IO_TIMEOUT = 16,
    parameter logic [5:0]  IO_REGION  = 6'h3C
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic        mem_re_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    input  logic [31:0] mem_rdata_i,
    output logic        io_re_o,
    output logic        io_we_o,
    input  logic        io_ack_i,
    input  logic [31:0] io_rdata_i
);

    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;
    localparam logic [2:0] F3_B     = 3'b000;
    localparam logic [2:0] F3_BU    = 3'b100;

    localparam int CNT_MAX = (MEM_RD_LAT > IO_TIMEOUT) ? MEM_RD_LAT : IO_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_RD_LAT - 1);
    localparam logic [CNT_W-1:0] IO_LAST  = CNT_W'(IO_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEM_ACC = 2'd1,
        IO_REQ  = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [31:0]      addr_q, wdata_q;
    logic [2:0]       funct3_q;
    logic             is_store_q, is_io_q;
    logic [31:0]      rdata_q;
    logic             err_q;

    logic             accept;
    logic             finish;
    logic [31:0]      fin_rdata;
    logic             fin_err;

    // Byte select by address offset, then sign/zero extend; anything that
    // is not a byte access is treated as a full word.
    function automatic logic [31:0] fmt_load(input logic [31:0] d,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  off);
        logic [31:0] sh;
        sh = d >> {off, 3'b000};
        case (f3)
            F3_B:    fmt_load = {{24{sh[7]}}, sh[7:0]};
            F3_BU:   fmt_load = {24'h0, sh[7:0]};
            default: fmt_load = d;
        endcase
    endfunction

    function automatic logic is_byte(input logic [2:0] f3);
        is_byte = (f3 == F3_B) || (f3 == F3_BU);
    endfunction

    assign accept = (state == IDLE) && req_valid_i &&
                    ((opcode_i == OP_LOAD) || (opcode_i == OP_STORE));

    // Bus address/data derive from the latched request so they stay stable
    // for the whole access; memory sees a word-aligned address.
    assign bus_addr_o  = is_io_q ? addr_q : {addr_q[31:2], 2'b00};
    assign bus_wdata_o = (funct3_q == F3_B) ? {4{wdata_q[7:0]}} : wdata_q;
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            funct3_q   <= '0;
            is_store_q <= 1'b0;
            is_io_q    <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (accept) begin
                addr_q     <= addr_i;
                wdata_q    <= wdata_i;
                funct3_q   <= funct3_i;
                is_store_q <= (opcode_i == OP_STORE);
                is_io_q    <= (addr_i[31:26] == IO_REGION);
            end
            // Result registers only change on entry to DONE so they hold
            // until the next completed access.
            if (finish) begin
                rdata_q <= fin_rdata;
                err_q   <= fin_err;
            end
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        finish    = 1'b0;
        fin_rdata = 32'h0;
        fin_err   = 1'b0;
        stall_o   = 1'b0;
        done_o    = 1'b0;
        mem_re_o  = 1'b0;
        mem_we_o  = 1'b0;
        mem_be_o  = 4'h0;
        io_re_o   = 1'b0;
        io_we_o   = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    stall_o = 1'b1;
                    cnt_d   = '0;
                    if (!is_byte(funct3_i) && (addr_i[1:0] != 2'b00)) begin
                        // Misaligned word: report error without touching the bus.
                        state_d = DONE;
                        finish  = 1'b1;
                        fin_err = 1'b1;
                    end else if (addr_i[31:26] == IO_REGION) begin
                        state_d = IO_REQ;
                    end else begin
                        state_d = MEM_ACC;
                    end
                end
            end

            MEM_ACC: begin
                stall_o = 1'b1;
                if (is_store_q) begin
                    mem_we_o = 1'b1;
                    mem_be_o = (funct3_q == F3_B) ? (4'b0001 << addr_q[1:0]) : 4'hF;
                    state_d  = DONE;
                    finish   = 1'b1;
                end else begin
                    mem_re_o = 1'b1;
                    mem_be_o = 4'hF;
                    if (cnt == MEM_LAST) begin
                        state_d   = DONE;
                        finish    = 1'b1;
                        fin_rdata = fmt_load(mem_rdata_i, funct3_q, addr_q[1:0]);
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
            end

            IO_REQ: begin
                stall_o = 1'b1;
                io_we_o = is_store_q;
                io_re_o = !is_store_q;
                // Ack is checked first so an ack on the timeout cycle wins.
                if (io_ack_i) begin
                    state_d   = DONE;
                    finish    = 1'b1;
                    fin_rdata = is_store_q ? 32'h0
                                           : fmt_load(io_rdata_i, funct3_q, addr_q[1:0]);
                end else if (cnt == IO_LAST) begin
                    state_d = DONE;
                    finish  = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

endmodule
`default_nettype wire
